// File: rtl/alu_pkg.sv
// Shared definitions for the saturating integer ALU and its sequential divider:
// opcode encoding, divider FSM states, N/V/Z flag bundle and saturation limits.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_t;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
    } alu_flags_t;

    // Largest signed value of a w-bit word, 2^(w-1)-1, as a raw bit pattern.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Smallest signed value of a w-bit word, -2^(w-1), as a raw w-bit pattern.
    function automatic logic [63:0] sat_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/alu_saturate.sv
// Clamp a (DATA_WIDTH+1)-bit signed value into DATA_WIDTH bits, flagging V on clamp.
// Purely combinational; shared by the add/sub/mul paths and the divider.
module alu_saturate
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH:0]   din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  v
);

    localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MINV = DATA_WIDTH'(sat_min(DATA_WIDTH));

    // Out of range exactly when the two top bits disagree; the top bit gives the direction.
    always_comb begin
        dout = din[DATA_WIDTH-1:0];
        v    = 1'b0;
        if (din[DATA_WIDTH] != din[DATA_WIDTH-1]) begin
            v    = 1'b1;
            dout = din[DATA_WIDTH] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/alu_divider_seq.sv
// Multi-cycle signed restoring divider with saturation and N/V/Z flags.
// Optional remainder output: define ALU_DIV_REMAINDER_EN to add the Rem port.
//
// state   | meaning
// IDLE    | waiting for start; clears busy/done left over from the last divide
// CALC    | one restoring step per cycle, DATA_WIDTH cycles, MSB first
// FIX     | apply signs, saturate, handle divide-by-zero, register results
// DONE    | pulse done for one cycle
module alu_divider_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  N,
    output logic                  V,
    output logic                  Z
`ifdef ALU_DIV_REMAINDER_EN
    ,
    output logic [DATA_WIDTH-1:0] Rem
`endif
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MINV = DATA_WIDTH'(sat_min(DATA_WIDTH));

    div_state_t            state;
    logic [CW-1:0]         cnt;
    logic                  sa;
    logic                  sb;
    logic                  bz;
    logic [DATA_WIDTH-1:0] dq;      // dividend magnitude shifting out, quotient bits shifting in
    logic [DATA_WIDTH-1:0] rem;     // partial remainder, always below |B| so W bits suffice
    logic [DATA_WIDTH:0]   mag_b;   // |B| needs W+1 bits for |-2^(W-1)|
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH:0]   q_signed;
    logic [DATA_WIDTH-1:0] q_sat;
    logic                  q_ovf;
    alu_flags_t            flags;

    assign trial    = {rem, dq[DATA_WIDTH-1]};
    assign q_signed = (sa ^ sb) ? (~{1'b0, dq} + 1'b1) : {1'b0, dq};

    assign N = flags.n;
    assign V = flags.v;
    assign Z = flags.z;

    alu_saturate #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
        .din  (q_signed),
        .dout (q_sat),
        .v    (q_ovf)
    );

    // Divider FSM with all outputs registered; latency is fixed regardless of operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            bz    <= 1'b0;
            dq    <= '0;
            rem   <= '0;
            mag_b <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Out   <= '0;
            flags <= '{n: 1'b0, v: 1'b0, z: 1'b1};
`ifdef ALU_DIV_REMAINDER_EN
            Rem   <= '0;
`else
            // remainder stays internal to the restoring datapath
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // busy still high here means done just fell: a start now is ignored
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        sa    <= A[DATA_WIDTH-1];
                        sb    <= B[DATA_WIDTH-1];
                        bz    <= (B == '0);
                        dq    <= A[DATA_WIDTH-1] ? (~A + 1'b1) : A;
                        mag_b <= B[DATA_WIDTH-1] ? ({1'b0, ~B} + 1'b1) : {1'b0, B};
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (trial >= mag_b) begin
                        rem <= DATA_WIDTH'(trial - mag_b);
                        dq  <= {dq[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= trial[DATA_WIDTH-1:0];
                        dq  <= {dq[DATA_WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (bz) begin
                        Out   <= sa ? MINV : MAXV;
                        flags <= '{n: sa, v: 1'b1, z: 1'b0};
                    end else begin
                        Out   <= q_sat;
                        flags <= '{n: q_sat[DATA_WIDTH-1], v: q_ovf, z: (q_sat == '0)};
                    end
`ifdef ALU_DIV_REMAINDER_EN
                    if (bz) begin
                        Rem <= '0;
                    end else begin
                        Rem <= sa ? (~rem + 1'b1) : rem;
                    end
`endif
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
